// File: rtl/reg_bank_seq.sv
// Sequencer for a negedge-clocked register bank with shared d/preset/clear lines.
// Runs on posedge so every bank input is stable half a cycle before the bank samples it.

module reg_bank_lane (
   input  logic q,
   input  logic shift_src,
   input  logic data,
   input  logic sel_load,
   input  logic sel_shift,
   input  logic force_en,
   input  logic force_val,
   output logic d,
   output logic nxt
);
   // d is what the bank loads on a 11 line code; nxt is what the cell holds after the edge
   assign d   = sel_load ? data : (sel_shift ? shift_src : q);
   assign nxt = force_en ? force_val : d;
endmodule

module reg_bank_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] ff_d,
   output logic             ff_preset,
   output logic             ff_clear,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q_mirror
);

   typedef enum logic [1:0] {OP_CLEAR, OP_SET, OP_LOAD, OP_SHIFT} op_e;
   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SHIFT, S_DONE} state_e;

   typedef struct packed {
      op_e              op;
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] cnt;
   } cmd_t;

   state_e           state, state_nxt;
   cmd_t             cmd_q;
   logic             sel_load, sel_shift, force_en, force_val, upd;
   logic [WIDTH-1:0] shift_src, q_nxt;

   // left shift: MSB drops out, serial-in enters at bit 0
   assign shift_src = {q_mirror[WIDTH-2:0], cmd_q.data[0]};

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      reg_bank_lane u_lane (
         .q         (q_mirror[i]),
         .shift_src (shift_src[i]),
         .data      (cmd_q.data[i]),
         .sel_load  (sel_load),
         .sel_shift (sel_shift),
         .force_en  (force_en),
         .force_val (force_val),
         .d         (ff_d[i]),
         .nxt       (q_nxt[i])
      );
   end

   assign busy = ~cmd_ready;

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      ff_preset = 1'b1;
      ff_clear  = 1'b1;
      sel_load  = 1'b0;
      sel_shift = 1'b0;
      force_en  = 1'b0;
      force_val = 1'b0;
      upd       = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_op != OP_SHIFT)  state_nxt = S_APPLY;
               else if (cmd_count != '0) state_nxt = S_SHIFT;
               else                      state_nxt = S_DONE;
            end
         end
         S_APPLY: begin
            upd       = 1'b1;
            state_nxt = S_DONE;
            case (cmd_q.op)
               OP_CLEAR: begin ff_clear  = 1'b0; force_en = 1'b1; force_val = 1'b0; end
               OP_SET:   begin ff_preset = 1'b0; force_en = 1'b1; force_val = 1'b1; end
               OP_LOAD:  sel_load = 1'b1;
               default:  ;
            endcase
         end
         S_SHIFT: begin
            sel_shift = 1'b1;
            upd       = 1'b1;
            if (cmd_q.cnt == CNT_W'(1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // reset clears the bank at the coming negedge regardless of state
      if (reset) begin
         ff_preset = 1'b1;
         ff_clear  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         q_mirror <= '0;
         cmd_q    <= '0;
      end else begin
         state <= state_nxt;
         if (cmd_valid && cmd_ready)
            cmd_q <= '{op: op_e'(cmd_op), data: cmd_data, cnt: cmd_count};
         else if (state == S_SHIFT)
            cmd_q.cnt <= cmd_q.cnt - CNT_W'(1);
         if (upd) q_mirror <= q_nxt;
      end
   end

endmodule
